// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: field limits, field widths, editor state
// encoding and the wrap-around step helpers used by the field editor.
package alarm_clock_pkg;

    localparam int HOURS_MAX   = 23;
    localparam int MINUTES_MAX = 59;
    localparam int HOURS_W     = 5;
    localparam int MINUTES_W   = 6;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_READY  = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } editor_state_t;

    function automatic logic [HOURS_W-1:0] step_hours(input logic [HOURS_W-1:0] val,
                                                      input logic up);
        logic [HOURS_W-1:0] res;
        if (up) begin
            res = (val == HOURS_W'(HOURS_MAX)) ? '0 : val + HOURS_W'(1);
        end else begin
            res = (val == '0) ? HOURS_W'(HOURS_MAX) : val - HOURS_W'(1);
        end
        return res;
    endfunction

    function automatic logic [MINUTES_W-1:0] step_minutes(input logic [MINUTES_W-1:0] val,
                                                          input logic up);
        logic [MINUTES_W-1:0] res;
        if (up) begin
            res = (val == MINUTES_W'(MINUTES_MAX)) ? '0 : val + MINUTES_W'(1);
        end else begin
            res = (val == '0) ? MINUTES_W'(MINUTES_MAX) : val - MINUTES_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for an asynchronous debounced button level, followed
// by a rising-edge detector on the synchronized level.
module button_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/time_field_editor.sv
// Applies up/down button steps to the selected hours or minutes field while
// editing, with hold-to-repeat, field blinking and a commit strobe on exit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_OFF    | not editing; working value and outputs hold
// ST_READY  | editing, waiting for a single-button press edge
// ST_DELAY  | button held after first step, waiting REPEAT_DELAY cycles
// ST_REPEAT | button still held, stepping every REPEAT_RATE cycles
module time_field_editor
    import alarm_clock_pkg::*;
#(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter int BLINK_HALF   = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 edit_mode,
    input  logic                 selected,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic [HOURS_W-1:0]   cur_hours,
    input  logic [MINUTES_W-1:0] cur_minutes,
    output logic [HOURS_W-1:0]   hours,
    output logic [MINUTES_W-1:0] minutes,
    output logic                 commit,
    output logic                 blink_on
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [RPT_W-1:0]   DELAY_TC = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]   RATE_TC  = RPT_W'(REPEAT_RATE - 1);
    localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_HALF - 1);

    logic up_level, up_rise;
    logic dn_level, dn_rise;

    button_sync_edge u_sync_up (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (btn_up),
        .level   (up_level),
        .rise    (up_rise)
    );

    button_sync_edge u_sync_down (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (btn_down),
        .level   (dn_level),
        .rise    (dn_rise)
    );

    editor_state_t        state_q,     state_d;
    logic [HOURS_W-1:0]   hours_q,     hours_d;
    logic [MINUTES_W-1:0] minutes_q,   minutes_d;
    logic                 commit_q,    commit_d;
    logic                 dir_up_q,    dir_up_d;
    logic                 sel_q,       sel_d;
    logic [RPT_W-1:0]     rpt_cnt_q,   rpt_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 phase_q,     phase_d;

    logic do_step;
    logic step_up;
    logic held_level;
    logic other_level;
    logic [RPT_W-1:0] rpt_tc;

    always_comb begin
        state_d     = state_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        commit_d    = 1'b0;
        dir_up_d    = dir_up_q;
        sel_d       = sel_q;
        rpt_cnt_d   = rpt_cnt_q;
        do_step     = 1'b0;
        step_up     = dir_up_q;
        held_level  = dir_up_q ? up_level : dn_level;
        other_level = dir_up_q ? dn_level : up_level;
        rpt_tc      = (state_q == ST_DELAY) ? DELAY_TC : RATE_TC;

        // Leaving edit mode takes priority over any step due this cycle.
        if (!edit_mode) begin
            state_d   = ST_OFF;
            rpt_cnt_d = '0;
            commit_d  = (state_q != ST_OFF);
        end else begin
            case (state_q)
                ST_OFF: begin
                    hours_d   = cur_hours;
                    minutes_d = cur_minutes;
                    state_d   = ST_READY;
                end
                ST_READY: begin
                    if (up_rise ^ dn_rise) begin
                        do_step   = 1'b1;
                        step_up   = up_rise;
                        dir_up_d  = up_rise;
                        sel_d     = selected;
                        rpt_cnt_d = '0;
                        state_d   = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!held_level || other_level || (selected != sel_q)) begin
                        rpt_cnt_d = '0;
                        state_d   = ST_READY;
                    end else if (rpt_cnt_q == rpt_tc) begin
                        do_step   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = ST_REPEAT;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                default: begin
                    state_d   = ST_OFF;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        if (do_step) begin
            if (selected) begin
                hours_d = step_hours(hours_q, step_up);
            end else begin
                minutes_d = step_minutes(minutes_q, step_up);
            end
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!edit_mode) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_TC) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_OFF;
            hours_q     <= '0;
            minutes_q   <= '0;
            commit_q    <= 1'b0;
            dir_up_q    <= 1'b0;
            sel_q       <= 1'b0;
            rpt_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            commit_q    <= commit_d;
            dir_up_q    <= dir_up_d;
            sel_q       <= sel_d;
            rpt_cnt_q   <= rpt_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Field is held solid while a button is actively adjusting it.
    assign blink_on = phase_q | (state_q == ST_DELAY) | (state_q == ST_REPEAT);
    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign commit   = commit_q;

endmodule
